// File: rtl/rv_pkg.sv
// Shared types for the rv core load/store path.
package rv_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2
    } mem_op_sz_e;

endpackage

// File: rtl/data_mem_hs.sv
// Handshaked word-organised data memory with byte-lane stores, extended loads,
// alignment/range checking and a configurable response latency.
module data_mem_hs
    import rv_pkg::*;
#(
    parameter int unsigned DepthWords  = 1024,
    parameter int unsigned ReadLatency = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  mem_op_sz_e  i_mem_size,
    input  logic        i_load_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err
);

    localparam int unsigned AW = $clog2(DepthWords);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem [DepthWords];

    logic [AW-1:0] idx;
    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          bad_size;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;

    assign idx          = i_addr[AW+1:2];
    assign accept       = (state_q == IDLE) && i_req_valid;
    assign out_of_range = {32'd0, i_addr} >= (64'(DepthWords) << 2);
    assign rd_word      = mem[idx];
    assign rd_byte      = rd_word[{i_addr[1:0], 3'b000} +: 8];
    assign rd_half      = i_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign err          = misaligned | out_of_range | bad_size;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        misaligned = 1'b0;
        bad_size   = 1'b0;
        be         = '0;
        wdata      = i_data;
        ld_data    = '0;
        case (i_mem_size)
            BYTE: begin
                be      = 4'b0001 << i_addr[1:0];
                wdata   = {4{i_data[7:0]}};
                ld_data = {{24{~i_load_unsigned & rd_byte[7]}}, rd_byte};
            end
            HWORD: begin
                misaligned = i_addr[0];
                be         = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{i_data[15:0]}};
                ld_data    = {{16{~i_load_unsigned & rd_half[15]}}, rd_half};
            end
            WORD: begin
                misaligned = |i_addr[1:0];
                be         = '1;
                ld_data    = rd_word;
            end
            default: bad_size = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (accept && i_we && !err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rsp_data_q <= (err || i_we) ? '0 : ld_data;
                rsp_err_q  <= err;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (ReadLatency > 1) begin
                        state_d = WAIT;
                        cnt_d   = 3'(ReadLatency - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rsp_data = rsp_data_q;
    assign o_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: dut 0 is 1024 words / latency 1,
// dut 1 is 16 words / latency 3.
module tb_data_mem_hs;
    import rv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];

    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_sz_e  size;
    logic        uns;

    data_mem_hs #(.DepthWords(1024), .ReadLatency(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst_n[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_we(we), .i_addr(addr), .i_data(wdata), .i_mem_size(size),
        .i_load_unsigned(uns),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0])
    );

    data_mem_hs #(.DepthWords(16), .ReadLatency(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_we(we), .i_addr(addr), .i_data(wdata), .i_mem_size(size),
        .i_load_unsigned(uns),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1])
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] sbq0[$];
    logic [32:0] sbq1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k] && rsp_valid[k] && rsp_ready[k]) begin
                if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d actual=%h required=none", k, rsp_data[k]);
                end else begin
                    if (k == 0) e = sbq0.pop_front();
                    else        e = sbq1.pop_front();
                    chk($sformatf("rsp_data dut%0d", k), rsp_data[k], e[31:0]);
                    chk($sformatf("rsp_err dut%0d", k), 32'(rsp_err[k]), 32'(e[32]));
                end
            end
        end
    end

    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input mem_op_sz_e sz, input logic u,
                         input logic e_err, input logic [31:0] e_data, input int hold);
        int          lat;
        logic [31:0] held_d;
        logic        held_e;
        we = w; addr = a; wdata = d; size = sz; uns = u;
        rsp_ready[k] = (hold == 0);
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        if (k == 0) sbq0.push_back({e_err, e_data});
        else        sbq1.push_back({e_err, e_data});
        req_valid[k] = 1'b1;
        step();
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin
            chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), (k == 0) ? 32'd1 : 32'd3);
        held_d = rsp_data[k];
        held_e = rsp_err[k];
        // A conflicting store is presented during the stall; RESP must ignore it.
        for (int i = 0; i < hold; i++) begin
            req_valid[k] = 1'b1; we = 1'b1; addr = 32'h0; wdata = '1; size = WORD;
            step();
            chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
            chk("stall_req_ready", 32'(req_ready[k]), 32'd0);
            chk("stall_data", rsp_data[k], held_d);
            chk("stall_err", 32'(rsp_err[k]), 32'(held_e));
        end
        rsp_ready[k] = 1'b1;
        step();
        req_valid[k] = 1'b0;
        chk("req_ready_after", 32'(req_ready[k]), 32'd1);
        chk("rsp_valid_after", 32'(rsp_valid[k]), 32'd0);
    endtask

    task automatic chk_reset(input int k);
        chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        chk("rst_rsp_data", rsp_data[k], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_op_sz_e bad;
        bad = mem_op_sz_e'(2'd3);
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
        end
        we = 1'b0; addr = '0; wdata = '0; size = WORD; uns = 1'b0;
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        step(); step();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        step();

        // dut0: 1024 words, latency 1
        issue(0, 1, 32'h10, 32'hDEADBEEF, WORD, 0, 0, 32'h0,        0);
        issue(0, 0, 32'h10, 32'h0,        WORD, 0, 0, 32'hDEADBEEF, 0);
        issue(0, 0, 32'h10, 32'h0,        BYTE, 0, 0, 32'hFFFFFFEF, 0);
        issue(0, 0, 32'h13, 32'h0,        BYTE, 1, 0, 32'h000000DE, 0);
        issue(0, 0, 32'h12, 32'h0,        HWORD, 1, 0, 32'h0000DEAD, 0);
        issue(0, 1, 32'h20, 32'h11223344, WORD, 0, 0, 32'h0,        0);
        issue(0, 1, 32'h21, 32'hFFFFFF80, BYTE, 0, 0, 32'h0,        0);
        issue(0, 0, 32'h21, 32'h0,        BYTE, 0, 0, 32'hFFFFFF80, 0);
        issue(0, 0, 32'h21, 32'h0,        BYTE, 1, 0, 32'h00000080, 0);
        issue(0, 0, 32'h20, 32'h0,        WORD, 1, 0, 32'h11228044, 0);
        issue(0, 1, 32'h30, 32'hAABBCCDD, WORD, 0, 0, 32'h0,        0);
        issue(0, 1, 32'h32, 32'h12348001, HWORD, 0, 0, 32'h0,       0);
        issue(0, 0, 32'h32, 32'h0,        HWORD, 0, 0, 32'hFFFF8001, 0);
        issue(0, 0, 32'h32, 32'h0,        HWORD, 1, 0, 32'h00008001, 0);
        issue(0, 0, 32'h30, 32'h0,        HWORD, 0, 0, 32'hFFFFCCDD, 0);
        issue(0, 0, 32'h30, 32'h0,        WORD, 0, 0, 32'h8001CCDD, 0);
        issue(0, 0, 32'h31, 32'h0,        HWORD, 0, 1, 32'h0,        0);
        issue(0, 1, 32'h22, 32'h55555555, WORD, 0, 1, 32'h0,        0);
        issue(0, 1, 32'h21, 32'h55555555, HWORD, 0, 1, 32'h0,       0);
        issue(0, 1, 32'h20, 32'h55555555, bad,  0, 1, 32'h0,        0);
        issue(0, 0, 32'h20, 32'h0,        bad,  0, 1, 32'h0,        0);
        issue(0, 0, 32'h20, 32'h0,        WORD, 0, 0, 32'h11228044, 0);

        // dut1: 16 words, latency 3
        issue(1, 1, 32'h00, 32'h0BADC0DE, WORD, 0, 0, 32'h0,        0);
        issue(1, 1, 32'h3C, 32'h12345678, WORD, 0, 0, 32'h0,        0);
        issue(1, 0, 32'h3C, 32'h0,        WORD, 0, 0, 32'h12345678, 0);
        issue(1, 1, 32'h40, 32'hCAFEF00D, WORD, 0, 1, 32'h0,        0);
        issue(1, 0, 32'h40, 32'h0,        WORD, 0, 1, 32'h0,        0);
        issue(1, 0, 32'h40, 32'h0,        BYTE, 1, 1, 32'h0,        0);
        issue(1, 0, 32'hFFFFFFFC, 32'h0,  WORD, 0, 1, 32'h0,        0);
        issue(1, 0, 32'h00, 32'h0,        WORD, 0, 0, 32'h0BADC0DE, 0);
        issue(1, 0, 32'h3F, 32'h0,        BYTE, 0, 0, 32'h00000012, 0);
        issue(1, 0, 32'h3E, 32'h0,        HWORD, 1, 0, 32'h00001234, 0);
        issue(1, 0, 32'h3C, 32'h0,        WORD, 0, 0, 32'h12345678, 5);
        issue(1, 0, 32'h00, 32'h0,        WORD, 0, 0, 32'h0BADC0DE, 0);

        // Reset while in WAIT drops the pending load.
        we = 1'b0; addr = 32'h3C; size = WORD; uns = 1'b0;
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        chk("wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("wait_req_ready", 32'(req_ready[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk_reset(1);
        step(); step();
        rst_n[1] = 1'b1;
        step();
        issue(1, 0, 32'h3C, 32'h0,        WORD, 0, 0, 32'h12345678, 0);

        step(); step();
        chk("sb_drain0", 32'(sbq0.size()), 32'd0);
        chk("sb_drain1", 32'(sbq1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
